// File: rtl/muldiv_sequencer.sv
`default_nettype none
// muldiv_sequencer: 32-step shift/add multiply and restoring divide owning the MIPS32 HI/LO pair.
// Optional feature macro MULDIV_SIGNED_EN adds MULT/DIV sign handling. Rev 1.0
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic        is_div;
  logic        b_zero;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opb;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_p;
  logic start_neg_a;
  logic start_neg_b;
  assign start_neg_a = op[0] & rs_val[31];
  assign start_neg_b = op[0] & rt_val[31];
  assign a_mag = start_neg_a ? -rs_val : rs_val;
  assign b_mag = start_neg_b ? -rt_val : rt_val;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag = rs_val;
  assign b_mag = rt_val;
`endif

  // Multiply: acc_lo holds the multiplier, shifted right as product bits enter from acc_hi.
  // Divide: acc_lo holds the dividend, shifted left as quotient bits enter at bit 0.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, opb};

  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      if (b_zero) res_lo = 32'hFFFF_FFFF;
`ifdef MULDIV_SIGNED_EN
      // With a zero divisor the remainder is |rs|, so restoring its sign yields rs_val.
      if (neg_a) res_hi = -acc_hi;
      if (neg_p && !b_zero) res_lo = -acc_lo;
`endif
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (neg_p) prod = -prod;
`endif
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      is_div      <= 1'b0;
      b_zero      <= 1'b0;
      acc_hi      <= 32'd0;
      acc_lo      <= 32'd0;
      opb         <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      neg_a       <= 1'b0;
      neg_p       <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            count  <= 5'd31;
            is_div <= op[1];
            b_zero <= (rt_val == 32'd0);
            acc_hi <= 32'd0;
            acc_lo <= op[1] ? a_mag : b_mag;
            opb    <= op[1] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_a  <= start_neg_a;
            neg_p  <= start_neg_a ^ start_neg_b;
`endif
          end
        end
        CALC: begin
          if (is_div) begin
            if (!div_diff[32]) begin
              acc_hi <= div_diff[31:0];
              acc_lo <= {acc_lo[30:0], 1'b1};
            end else begin
              acc_hi <= div_shift[31:0];
              acc_lo <= {acc_lo[30:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIN;
        end
        FIN: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= is_div & b_zero;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
